// File: rtl/framestore_responder_if.sv
// Framestore "de_" request bus: one initiator (pixel engine) to one responder.
interface framestore_responder_if;
  logic        de_req;
  logic        de_rnw;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic [31:0] de_w_data;
  logic        de_ack;
  logic [31:0] de_r_data;

  modport master (
    output de_req, de_rnw, de_addr, de_nbyte, de_w_data,
    input  de_ack, de_r_data
  );

  modport slave (
    input  de_req, de_rnw, de_addr, de_nbyte, de_w_data,
    output de_ack, de_r_data
  );
endinterface

// File: rtl/framestore_responder.sv
// Responder end of the framestore bus: one transfer per handshake, issued to a
// 1-cycle-latency synchronous SRAM port, completed with a one-cycle de_ack.
`ifndef TOTAL_ADDRESSES
`define TOTAL_ADDRESSES 262144
`endif

module framestore_responder #(
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned ADDR_LIMIT  = `TOTAL_ADDRESSES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  framestore_responder_if.slave  de,
  output logic                   mem_en,
  output logic [3:0]             mem_we,
  output logic [17:0]            mem_addr,
  output logic [31:0]            mem_wdata,
  input  logic [31:0]            mem_rdata,
  output logic                   busy,
  output logic                   addr_err
);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, ACK} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        rnw_q, ok_q;
  logic [17:0] addr_q;
  logic [3:0]  nbyte_q;
  logic [31:0] wdata_q;

  logic        accept, in_range, wait_done;
  logic        cur_rnw, cur_ok;
  logic [17:0] cur_addr;
  logic [3:0]  cur_nbyte;
  logic [31:0] cur_wdata;

  assign accept    = (state == IDLE) && de.de_req && !de.de_ack;
  assign in_range  = 32'(de.de_addr) < ADDR_LIMIT;
  assign wait_done = (wait_cnt == 4'(WAIT_CYCLES - 1));
  assign busy      = (state != IDLE);

  // With no wait states ACCESS follows IDLE directly, so the SRAM strobe must
  // be built from the live bus fields in IDLE and from the latched copy after.
  always_comb begin
    cur_rnw   = rnw_q;
    cur_ok    = ok_q;
    cur_addr  = addr_q;
    cur_nbyte = nbyte_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_rnw   = de.de_rnw;
      cur_ok    = in_range;
      cur_addr  = de.de_addr;
      cur_nbyte = de.de_nbyte;
      cur_wdata = de.de_w_data;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
      WAIT:    if (wait_done) state_nxt = ACCESS;
      ACCESS:  state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == WAIT && !wait_done) ? wait_cnt + 4'd1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnw_q    <= 1'b0;
      ok_q     <= 1'b0;
      addr_q   <= '0;
      nbyte_q  <= '0;
      wdata_q  <= '0;
      addr_err <= 1'b0;
    end else if (accept) begin
      rnw_q   <= de.de_rnw;
      ok_q    <= in_range;
      addr_q  <= de.de_addr;
      nbyte_q <= de.de_nbyte;
      wdata_q <= de.de_w_data;
      if (!in_range) addr_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en       <= 1'b0;
      mem_we       <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      de.de_ack    <= 1'b0;
      de.de_r_data <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= '0;
      de.de_ack <= (state_nxt == ACK);
      if (state_nxt == ACCESS && cur_ok) begin
        mem_en   <= 1'b1;
        mem_addr <= cur_addr;
        if (!cur_rnw) begin
          mem_we    <= ~cur_nbyte;
          mem_wdata <= cur_wdata;
        end
      end
      // Out-of-range reads complete with zero data.
      if (state == ACK && rnw_q) de.de_r_data <= ok_q ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_framestore_responder.sv
// Bench for framestore_responder: two instances (0 and 3 wait states) on
// behavioural SRAMs, checked against a spec-level memory reference model.
module tb_framestore_responder;
  localparam int unsigned LIMIT = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        sel, req, rnw;
  logic [17:0] addr;
  logic [3:0]  nbyte;
  logic [31:0] wdata;

  framestore_responder_if bif0 ();
  framestore_responder_if bif1 ();

  assign bif0.de_req = req & ~sel;
  assign bif1.de_req = req & sel;
  assign bif0.de_rnw = rnw;        assign bif1.de_rnw = rnw;
  assign bif0.de_addr = addr;      assign bif1.de_addr = addr;
  assign bif0.de_nbyte = nbyte;    assign bif1.de_nbyte = nbyte;
  assign bif0.de_w_data = wdata;   assign bif1.de_w_data = wdata;

  logic        en [2];
  logic [3:0]  we [2];
  logic [17:0] ma [2];
  logic [31:0] wd [2];
  logic [31:0] mrd [2];
  logic        busy [2];
  logic        err [2];

  framestore_responder #(.WAIT_CYCLES(0), .ADDR_LIMIT(LIMIT)) dut0 (
    .clk(clk), .rst_n(rst_n), .de(bif0),
    .mem_en(en[0]), .mem_we(we[0]), .mem_addr(ma[0]), .mem_wdata(wd[0]),
    .mem_rdata(mrd[0]), .busy(busy[0]), .addr_err(err[0]));

  framestore_responder #(.WAIT_CYCLES(3), .ADDR_LIMIT(LIMIT)) dut1 (
    .clk(clk), .rst_n(rst_n), .de(bif1),
    .mem_en(en[1]), .mem_we(we[1]), .mem_addr(ma[1]), .mem_wdata(wd[1]),
    .mem_rdata(mrd[1]), .busy(busy[1]), .addr_err(err[1]));

  logic        ack;
  logic [31:0] rdata;
  assign ack   = sel ? bif1.de_ack : bif0.de_ack;
  assign rdata = sel ? bif1.de_r_data : bif0.de_r_data;

  // Behavioural SRAMs with a bench-side poke port for preloading.
  logic [31:0] sram0 [LIMIT];
  logic [31:0] sram1 [LIMIT];
  logic        poke, psel;
  logic [5:0]  paddr;
  logic [31:0] pdata;

  always @(posedge clk) begin
    if (poke && !psel) sram0[paddr] <= pdata;
    else if (en[0])
      for (int i = 0; i < 4; i++) if (we[0][i]) sram0[ma[0][5:0]][8*i +: 8] <= wd[0][8*i +: 8];
    mrd[0] <= sram0[ma[0][5:0]];
  end

  always @(posedge clk) begin
    if (poke && psel) sram1[paddr] <= pdata;
    else if (en[1])
      for (int i = 0; i < 4; i++) if (we[1][i]) sram1[ma[1][5:0]][8*i +: 8] <= wd[1][8*i +: 8];
    mrd[1] <= sram1[ma[1][5:0]];
  end

  int          en_cnt [2];
  int          ack_cnt [2];
  logic [3:0]  last_we [2];
  logic [17:0] last_ma [2];

  initial begin
    en_cnt[0] = 0; en_cnt[1] = 0; ack_cnt[0] = 0; ack_cnt[1] = 0;
  end

  always @(negedge clk) begin
    if (en[0]) begin en_cnt[0]++; last_we[0] = we[0]; last_ma[0] = ma[0]; end
    if (en[1]) begin en_cnt[1]++; last_we[1] = we[1]; last_ma[1] = ma[1]; end
    if (bif0.de_ack) ack_cnt[0]++;
    if (bif1.de_ack) ack_cnt[1]++;
  end

  logic [31:0] ref_mem [2][LIMIT];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic preload(input int s, input int a, input logic [31:0] v);
    @(negedge clk);
    poke = 1'b1; psel = s[0]; paddr = a[5:0]; pdata = v;
    @(negedge clk);
    poke = 1'b0;
    ref_mem[s][a] = v;
  endtask

  // One handshake; lat = cycles from first sampled request to ack; rd taken the cycle after ack.
  task automatic xfer(input logic r, input logic [17:0] a, input logic [3:0] nb,
                      input logic [31:0] d, input logic scramble,
                      output int lat, output logic [31:0] rd);
    @(negedge clk);
    rnw = r; addr = a; nbyte = nb; wdata = d; req = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1 && scramble) begin
        addr = 18'($urandom); nbyte = 4'($urandom); wdata = $urandom;
      end
    end while (!ack && lat < 50);
    req = 1'b0;
    @(negedge clk);
    rd = rdata;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; sel = 1'b0; poke = 1'b0; psel = 1'b0;
    rnw = 1'b0; addr = '0; nbyte = '0; wdata = '0; paddr = '0; pdata = '0;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < int'(LIMIT); a++) preload(s, a, (a == 7) ? 32'hFFFF_FFFF : $urandom);
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({(s == 0) ? bif0.de_ack : bif1.de_ack, (s == 0) ? bif0.de_r_data : bif1.de_r_data,
           en[s], we[s], ma[s], wd[s], busy[s], err[s]} !== '0) begin
        n_fail++; $display("FAIL reset_outputs dut%0d: some output nonzero, required all 0", s);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b%b required 00", busy[0], busy[1]);
    end
  endtask

  task automatic test_write_read();
    int lat, e0; logic [31:0] rd;
    sel = 1'b0; e0 = en_cnt[0];
    xfer(1'b0, 18'd5, 4'h0, 32'hAABB_CCDD, 1'b0, lat, rd);
    ref_mem[0][5] = 32'hAABB_CCDD;
    n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL wr_latency: got %0d required 2", lat); end
    n_cmp++; if (last_we[0] !== 4'hF || last_ma[0] !== 18'd5 || en_cnt[0] - e0 !== 1) begin
      n_fail++; $display("FAIL wr_strobe: we=%h addr=%0d pulses=%0d required F/5/1", last_we[0], last_ma[0], en_cnt[0] - e0);
    end
    xfer(1'b1, 18'd5, 4'h0, 32'h0, 1'b0, lat, rd);
    n_cmp++; if (rd !== ref_mem[0][5]) begin n_fail++; $display("FAIL rd_back: got %h required %h", rd, ref_mem[0][5]); end
  endtask

  task automatic test_partial();
    int lat, e0; logic [31:0] rd;
    sel = 1'b0;
    xfer(1'b0, 18'd7, 4'b0001, 32'h1122_3344, 1'b0, lat, rd);
    n_cmp++; if (last_we[0] !== 4'b1110) begin n_fail++; $display("FAIL partial_we: got %b required 1110", last_we[0]); end
    xfer(1'b1, 18'd7, 4'h0, 32'h0, 1'b0, lat, rd);
    n_cmp++; if (rd !== 32'h1122_33FF) begin n_fail++; $display("FAIL partial_rd: got %h required 112233ff", rd); end
    e0 = en_cnt[0];
    xfer(1'b0, 18'd7, 4'hF, 32'h5555_5555, 1'b0, lat, rd);
    n_cmp++; if (en_cnt[0] - e0 !== 1 || last_we[0] !== 4'h0 || lat !== 2) begin
      n_fail++; $display("FAIL nobyte_wr: pulses=%0d we=%h lat=%0d required 1/0/2", en_cnt[0] - e0, last_we[0], lat);
    end
    xfer(1'b1, 18'd7, 4'h0, 32'h0, 1'b0, lat, rd);
    n_cmp++; if (rd !== 32'h1122_33FF) begin n_fail++; $display("FAIL nobyte_rd: got %h required 112233ff", rd); end
    ref_mem[0][7] = 32'h1122_33FF;
  endtask

  task automatic test_back_to_back();
    int t, prev, cnt; logic pend;
    sel = 1'b0;
    for (int i = 0; i < 4; i++) preload(0, 20 + i, {8'(8'hA0 + i), 24'($urandom)});
    @(negedge clk);
    rnw = 1'b1; addr = 18'd20; req = 1'b1;
    t = 0; prev = 0; cnt = 0; pend = 1'b0;
    while (cnt < 4 && t < 100) begin
      @(negedge clk); t++;
      if (pend) begin
        n_cmp++; if (rdata !== ref_mem[0][20 + cnt - 1]) begin
          n_fail++; $display("FAIL b2b_data%0d: got %h required %h", cnt - 1, rdata, ref_mem[0][20 + cnt - 1]);
        end
        pend = 1'b0;
      end
      if (ack) begin
        n_cmp++; if (t - prev !== ((cnt == 0) ? 2 : 3)) begin
          n_fail++; $display("FAIL b2b_spacing%0d: got %0d required %0d", cnt, t - prev, (cnt == 0) ? 2 : 3);
        end
        prev = t; cnt++; addr = 18'(20 + cnt); pend = 1'b1;
        if (cnt == 4) req = 1'b0;
      end
    end
    @(negedge clk);
    n_cmp++; if (cnt !== 4 || rdata !== ref_mem[0][23]) begin
      n_fail++; $display("FAIL b2b_last: acks=%0d data=%h required 4/%h", cnt, rdata, ref_mem[0][23]);
    end
  endtask

  task automatic test_out_of_range();
    int lat, e0; logic [31:0] rd;
    sel = 1'b0;
    n_cmp++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b required 0", err[0]); end
    e0 = en_cnt[0];
    xfer(1'b1, 18'(LIMIT), 4'h0, 32'h0, 1'b0, lat, rd);
    n_cmp++; if (lat !== 2 || rd !== 32'h0) begin n_fail++; $display("FAIL oor_read: lat=%0d data=%h required 2/0", lat, rd); end
    n_cmp++; if (en_cnt[0] !== e0 || err[0] !== 1'b1) begin
      n_fail++; $display("FAIL oor_flags: pulses=%0d err=%b required 0/1", en_cnt[0] - e0, err[0]);
    end
    xfer(1'b0, 18'd100, 4'h0, 32'hDEAD_BEEF, 1'b0, lat, rd);
    n_cmp++; if (en_cnt[0] !== e0 || lat !== 2 || rd !== 32'h0) begin
      n_fail++; $display("FAIL oor_write: pulses=%0d lat=%0d data=%h required 0/2/0", en_cnt[0] - e0, lat, rd);
    end
  endtask

  task automatic test_wait();
    int lat; logic [31:0] rd, d;
    sel = 1'b1;
    xfer(1'b1, 18'd3, 4'h0, 32'h0, 1'b0, lat, rd);
    n_cmp++; if (lat !== 5 || rd !== ref_mem[1][3]) begin
      n_fail++; $display("FAIL wait_read: lat=%0d data=%h required 5/%h", lat, rd, ref_mem[1][3]);
    end
    d = $urandom;
    xfer(1'b0, 18'd4, 4'h0, d, 1'b1, lat, rd);
    ref_mem[1][4] = d;
    xfer(1'b1, 18'd4, 4'h0, 32'h0, 1'b1, lat, rd);
    n_cmp++; if (lat !== 5 || rd !== d) begin n_fail++; $display("FAIL wait_wr_rd: lat=%0d data=%h required 5/%h", lat, rd, d); end
  endtask

  task automatic test_reset_mid();
    int lat, a0; logic [31:0] rd;
    sel = 1'b1; a0 = ack_cnt[1];
    @(negedge clk); rnw = 1'b0; addr = 18'd9; nbyte = 4'h0; wdata = ~ref_mem[1][9]; req = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b required 1", busy[1]); end
    rst_n = 1'b0; req = 1'b0;
    #1;
    n_cmp++; if ({bif1.de_ack, bif1.de_r_data, en[1], we[1], ma[1], wd[1], busy[1], err[1]} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: some output nonzero, required all 0");
    end
    repeat (2) @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++; if (ack_cnt[1] !== a0 || sram1[9] !== ref_mem[1][9]) begin
      n_fail++; $display("FAIL mid_abandon: acks=%0d mem=%h required 0/%h", ack_cnt[1] - a0, sram1[9], ref_mem[1][9]);
    end
    xfer(1'b1, 18'd9, 4'h0, 32'h0, 1'b0, lat, rd);
    n_cmp++; if (lat !== 5 || rd !== ref_mem[1][9]) begin n_fail++; $display("FAIL mid_recover: lat=%0d data=%h required 5/%h", lat, rd, ref_mem[1][9]); end

    sel = 1'b0; a0 = ack_cnt[0];
    @(negedge clk); rnw = 1'b0; addr = 18'd10; nbyte = 4'h0; wdata = ~ref_mem[0][10]; req = 1'b1;
    @(negedge clk);
    n_cmp++; if (en[0] !== 1'b1) begin n_fail++; $display("FAIL acc_strobe: got %b required 1", en[0]); end
    rst_n = 1'b0; req = 1'b0;
    #1;
    n_cmp++; if (en[0] !== 1'b0 || we[0] !== 4'h0 || ma[0] !== 18'd0) begin
      n_fail++; $display("FAIL acc_reset: en=%b we=%h addr=%0d required 0/0/0", en[0], we[0], ma[0]);
    end
    repeat (2) @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (ack_cnt[0] !== a0 || sram0[10] !== ref_mem[0][10]) begin
      n_fail++; $display("FAIL acc_abandon: acks=%0d mem=%h required 0/%h", ack_cnt[0] - a0, sram0[10], ref_mem[0][10]);
    end
  endtask

  task automatic test_random();
    int lat, e0, a; logic r, ok, seen; logic [3:0] nb; logic [31:0] d, rd, exp, rhold;
    sel = 1'b0; seen = 1'b0;
    xfer(1'b1, 18'd1, 4'h0, 32'h0, 1'b0, lat, rd);
    rhold = ref_mem[0][1];
    for (int n = 0; n < 40; n++) begin
      r = 1'($urandom); a = $urandom_range(0, 69); nb = 4'($urandom); d = $urandom;
      ok = (a < int'(LIMIT)); e0 = en_cnt[0];
      xfer(r, 18'(a), nb, d, 1'($urandom), lat, rd);
      if (!ok) seen = 1'b1;
      n_cmp++; if (lat !== 2 || en_cnt[0] - e0 !== int'(ok)) begin
        n_fail++; $display("FAIL rnd%0d_timing: lat=%0d pulses=%0d required 2/%0d", n, lat, en_cnt[0] - e0, ok);
      end
      if (r) begin
        exp = ok ? ref_mem[0][a] : 32'h0;
        rhold = exp;
      end else begin
        exp = rhold;
        if (ok) for (int i = 0; i < 4; i++) if (!nb[i]) ref_mem[0][a][8*i +: 8] = d[8*i +: 8];
        n_cmp++; if (ok && last_we[0] !== ~nb) begin n_fail++; $display("FAIL rnd%0d_we: got %b required %b", n, last_we[0], ~nb); end
      end
      n_cmp++; if (rd !== exp || err[0] !== seen) begin
        n_fail++; $display("FAIL rnd%0d_data: data=%h err=%b required %h/%b", n, rd, err[0], exp, seen);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_back_to_back();
    test_out_of_range();
    test_wait();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
